// File: rtl/vec_batch_ctrl.sv
// Batch scheduler: loads REF_NO reference vectors into the comparator slots, streams
// query sub-vectors to the compare path, then waits out the comparator latency.
module vec_batch_ctrl #(
    parameter int BUS_WIDTH       = 128,
    parameter int SUB_VEC_NO      = 8,
    parameter int REF_NO          = 4,
    parameter int VEC_ID_WIDTH    = 8,
    parameter int DRAIN_CYCLES    = 4,
    parameter int BATCH_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [BUS_WIDTH-1:0]          up_Vector,
    input  logic [VEC_ID_WIDTH-1:0]       up_VecID,
    input  logic                          up_Valid,
    input  logic                          up_Last,
    output logic                          up_Ready,
    output logic [BUS_WIDTH-1:0]          ref_Vector,
    output logic [REF_NO-1:0]             ref_WrEn,
    output logic [$clog2(SUB_VEC_NO)-1:0] ref_SubIdx,
    output logic [BUS_WIDTH-1:0]          cmp_Vector,
    output logic [VEC_ID_WIDTH-1:0]       cmp_VecID,
    output logic                          cmp_Valid,
    output logic                          cmp_Last,
    input  logic                          cmp_Ready,
    output logic                          batch_Busy,
    output logic                          batch_Done,
    output logic [BATCH_CNT_WIDTH-1:0]    batch_Cnt,
    output logic                          err_Frame
);

    localparam int SW = $clog2(SUB_VEC_NO);
    localparam int RW = (REF_NO > 1) ? $clog2(REF_NO) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [SW-1:0] SUB_LAST   = SW'(SUB_VEC_NO - 1);
    localparam logic [RW-1:0] REF_LAST   = RW'(REF_NO - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CMP   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                     state, state_n;
    logic [SW-1:0]              sub_cnt, sub_cnt_n;
    logic [RW-1:0]              ref_idx, ref_idx_n;
    logic [DW-1:0]              drain_cnt, drain_cnt_n;
    logic [BUS_WIDTH-1:0]       ref_Vector_n, cmp_Vector_n;
    logic [REF_NO-1:0]          ref_WrEn_n;
    logic [SW-1:0]              ref_SubIdx_n;
    logic [VEC_ID_WIDTH-1:0]    cmp_VecID_n;
    logic                       cmp_Valid_n, cmp_Last_n;
    logic                       batch_Done_n, err_Frame_n;
    logic [BATCH_CNT_WIDTH-1:0] batch_Cnt_n;
    logic                       xfer;

    function automatic logic [SW-1:0] sub_next(input logic [SW-1:0] c);
        return (c == SUB_LAST) ? '0 : c + SW'(1);
    endfunction

    // Ready looks only at state and the compare output handshake, never at up_Valid
    always_comb begin
        case (state)
            S_LOAD:  up_Ready = 1'b1;
            S_CMP:   up_Ready = !cmp_Valid || cmp_Ready;
            default: up_Ready = 1'b0;
        endcase
    end

    assign xfer       = up_Valid && up_Ready;
    assign batch_Busy = (state != S_LOAD);

    always_comb begin
        state_n      = state;
        sub_cnt_n    = sub_cnt;
        ref_idx_n    = ref_idx;
        drain_cnt_n  = drain_cnt;
        ref_Vector_n = ref_Vector;
        ref_WrEn_n   = '0;
        ref_SubIdx_n = ref_SubIdx;
        cmp_Vector_n = cmp_Vector;
        cmp_VecID_n  = cmp_VecID;
        cmp_Valid_n  = cmp_Valid;
        cmp_Last_n   = cmp_Last;
        batch_Done_n = 1'b0;
        batch_Cnt_n  = batch_Cnt;
        err_Frame_n  = 1'b0;

        case (state)
            S_LOAD: begin
                if (xfer) begin
                    ref_Vector_n = up_Vector;
                    ref_WrEn_n   = REF_NO'(1) << ref_idx;
                    ref_SubIdx_n = sub_cnt;
                    if (up_Last) begin
                        // Batch ended before the reference set was complete: restart loading
                        err_Frame_n = 1'b1;
                        sub_cnt_n   = '0;
                        ref_idx_n   = '0;
                    end else if (sub_cnt == SUB_LAST) begin
                        sub_cnt_n = '0;
                        if (ref_idx == REF_LAST) begin
                            ref_idx_n = '0;
                            state_n   = S_CMP;
                        end else begin
                            ref_idx_n = ref_idx + RW'(1);
                        end
                    end else begin
                        sub_cnt_n = sub_cnt + SW'(1);
                    end
                end
            end

            S_CMP: begin
                if (xfer) begin
                    cmp_Vector_n = up_Vector;
                    cmp_VecID_n  = up_VecID;
                    cmp_Valid_n  = 1'b1;
                    cmp_Last_n   = (sub_cnt == SUB_LAST) || up_Last;
                    sub_cnt_n    = sub_next(sub_cnt);
                    if (up_Last) begin
                        state_n     = S_DRAIN;
                        err_Frame_n = (sub_cnt != SUB_LAST);
                    end
                end else if (cmp_Ready) begin
                    cmp_Valid_n = 1'b0;
                end
            end

            S_DRAIN: begin
                if (cmp_Ready)
                    cmp_Valid_n = 1'b0;
                // Latency count starts only once the final word has left the output register
                if (!cmp_Valid) begin
                    if (drain_cnt == DRAIN_LAST) begin
                        batch_Done_n = 1'b1;
                        batch_Cnt_n  = batch_Cnt + BATCH_CNT_WIDTH'(1);
                        drain_cnt_n  = '0;
                        sub_cnt_n    = '0;
                        ref_idx_n    = '0;
                        state_n      = S_LOAD;
                    end else begin
                        drain_cnt_n = drain_cnt + DW'(1);
                    end
                end
            end

            default: state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_LOAD;
            sub_cnt    <= '0;
            ref_idx    <= '0;
            drain_cnt  <= '0;
            ref_Vector <= '0;
            ref_WrEn   <= '0;
            ref_SubIdx <= '0;
            cmp_Vector <= '0;
            cmp_VecID  <= '0;
            cmp_Valid  <= 1'b0;
            cmp_Last   <= 1'b0;
            batch_Done <= 1'b0;
            batch_Cnt  <= '0;
            err_Frame  <= 1'b0;
        end else begin
            state      <= state_n;
            sub_cnt    <= sub_cnt_n;
            ref_idx    <= ref_idx_n;
            drain_cnt  <= drain_cnt_n;
            ref_Vector <= ref_Vector_n;
            ref_WrEn   <= ref_WrEn_n;
            ref_SubIdx <= ref_SubIdx_n;
            cmp_Vector <= cmp_Vector_n;
            cmp_VecID  <= cmp_VecID_n;
            cmp_Valid  <= cmp_Valid_n;
            cmp_Last   <= cmp_Last_n;
            batch_Done <= batch_Done_n;
            batch_Cnt  <= batch_Cnt_n;
            err_Frame  <= err_Frame_n;
        end
    end

endmodule

// File: tb/tb_vec_batch_ctrl.sv
// Directed bench for vec_batch_ctrl: scoreboard of expected reference writes and
// compare words, plus framing, drain latency, reset and counter-wrap checks.
module tb_vec_batch_ctrl;

    localparam int BW  = 32;
    localparam int SV  = 2;
    localparam int RN  = 2;
    localparam int IW  = 8;
    localparam int DC  = 3;
    localparam int BCW = 2;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [BW-1:0]  up_Vector = '0;
    logic [IW-1:0]  up_VecID = '0;
    logic           up_Valid = 1'b0;
    logic           up_Last = 1'b0;
    logic           up_Ready;
    logic [BW-1:0]  ref_Vector;
    logic [RN-1:0]  ref_WrEn;
    logic [0:0]     ref_SubIdx;
    logic [BW-1:0]  cmp_Vector;
    logic [IW-1:0]  cmp_VecID;
    logic           cmp_Valid;
    logic           cmp_Last;
    logic           cmp_Ready = 1'b1;
    logic           batch_Busy;
    logic           batch_Done;
    logic [BCW-1:0] batch_Cnt;
    logic           err_Frame;

    vec_batch_ctrl #(
        .BUS_WIDTH(BW), .SUB_VEC_NO(SV), .REF_NO(RN), .VEC_ID_WIDTH(IW),
        .DRAIN_CYCLES(DC), .BATCH_CNT_WIDTH(BCW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .up_Vector(up_Vector), .up_VecID(up_VecID), .up_Valid(up_Valid),
        .up_Last(up_Last), .up_Ready(up_Ready),
        .ref_Vector(ref_Vector), .ref_WrEn(ref_WrEn), .ref_SubIdx(ref_SubIdx),
        .cmp_Vector(cmp_Vector), .cmp_VecID(cmp_VecID), .cmp_Valid(cmp_Valid),
        .cmp_Last(cmp_Last), .cmp_Ready(cmp_Ready),
        .batch_Busy(batch_Busy), .batch_Done(batch_Done),
        .batch_Cnt(batch_Cnt), .err_Frame(err_Frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RN-1:0] wren;
        logic [0:0]    sub;
        logic [BW-1:0] vec;
    } ref_t;

    typedef struct packed {
        logic [BW-1:0] vec;
        logic [IW-1:0] id;
        logic          last;
    } cmp_t;

    ref_t ref_q[$];
    cmp_t cmp_q[$];
    ref_t r_exp;
    cmp_t c_exp;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every reference write and every compare handshake pops one expectation
    always @(negedge clk) begin
        if (ref_WrEn != '0) begin
            if (ref_q.size() == 0) begin
                chk("ref_unexpected", 64'(ref_WrEn), 64'd0);
            end else begin
                r_exp = ref_q.pop_front();
                chk("ref_wren", 64'(ref_WrEn), 64'(r_exp.wren));
                chk("ref_subidx", 64'(ref_SubIdx), 64'(r_exp.sub));
                chk("ref_vector", 64'(ref_Vector), 64'(r_exp.vec));
            end
        end
        if (cmp_Valid && cmp_Ready) begin
            if (cmp_q.size() == 0) begin
                chk("cmp_unexpected", 64'(cmp_Vector), 64'd0);
            end else begin
                c_exp = cmp_q.pop_front();
                chk("cmp_vector", 64'(cmp_Vector), 64'(c_exp.vec));
                chk("cmp_vecid", 64'(cmp_VecID), 64'(c_exp.id));
                chk("cmp_last", 64'(cmp_Last), 64'(c_exp.last));
            end
        end
        if (batch_Done) done_cnt++;
        if (err_Frame) err_cnt++;
    end

    task automatic send(input logic [BW-1:0] v, input logic [IW-1:0] id, input logic last);
        logic rdy;
        logic accepted;
        accepted  = 1'b0;
        up_Vector = v;
        up_VecID  = id;
        up_Valid  = 1'b1;
        up_Last   = last;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            rdy = up_Ready;
            @(posedge clk);
            #1;
            accepted = rdy;
        end
        if (!accepted) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        up_Valid = 1'b0;
        up_Last  = 1'b0;
    endtask

    task automatic push_ref(input int r, input logic [BW-1:0] v);
        ref_t e;
        e.wren = RN'(1 << (r / SV));
        e.sub  = 1'(r % SV);
        e.vec  = v;
        ref_q.push_back(e);
    endtask

    task automatic push_cmp(input logic [BW-1:0] v, input logic [IW-1:0] id, input logic last);
        cmp_t e;
        e.vec  = v;
        e.id   = id;
        e.last = last;
        cmp_q.push_back(e);
    endtask

    task automatic wait_done(output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            n++;
            seen = batch_Done;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic load_refs(input logic [BW-1:0] base, input logic [IW-1:0] idb);
        for (int r = 0; r < RN * SV; r++) begin
            push_ref(r, base + BW'(r));
            send(base + BW'(r), idb + IW'(r / SV), 1'b0);
        end
        chk("busy_in_cmp", 64'(batch_Busy), 64'd1);
    endtask

    // Finish a batch already in DRAIN; batch_Done appears DC edges after the last compare handshake
    task automatic finish_batch(input logic [BCW-1:0] exp_cnt);
        int n;
        idle();
        chk("ready_in_drain", 64'(up_Ready), 64'd0);
        wait_done(n);
        chk("done_latency", 64'(n), 64'(DC + 2));
        chk("batch_cnt", 64'(batch_Cnt), 64'(exp_cnt));
        @(negedge clk);
        chk("done_single_pulse", 64'(batch_Done), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_batch(input logic [BW-1:0] base, input logic [IW-1:0] idb,
                            input logic bp, input logic [BCW-1:0] exp_cnt);
        logic [BW-1:0] qv;
        logic [IW-1:0] qid;
        load_refs(base, idb);
        for (int q = 0; q < 2 * SV; q++) begin
            qv  = base + BW'(RN * SV + q);
            qid = idb + IW'(RN + q / SV);
            if (bp && q == 1) begin
                cmp_Ready = 1'b0;
                up_Vector = qv;
                up_VecID  = qid;
                up_Valid  = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_cmp_vector", 64'(cmp_Vector), 64'(base + BW'(RN * SV)));
                    chk("bp_up_ready", 64'(up_Ready), 64'd0);
                    chk("bp_cmp_valid", 64'(cmp_Valid), 64'd1);
                end
                @(posedge clk);
                #1;
                cmp_Ready = 1'b1;
            end
            push_cmp(qv, qid, 1'(q % SV == SV - 1));
            send(qv, qid, 1'(q == 2 * SV - 1));
        end
        finish_batch(exp_cnt);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ref_vector"}, 64'(ref_Vector), 64'd0);
        chk({tag, "_ref_wren"}, 64'(ref_WrEn), 64'd0);
        chk({tag, "_ref_subidx"}, 64'(ref_SubIdx), 64'd0);
        chk({tag, "_cmp_vector"}, 64'(cmp_Vector), 64'd0);
        chk({tag, "_cmp_vecid"}, 64'(cmp_VecID), 64'd0);
        chk({tag, "_cmp_valid"}, 64'(cmp_Valid), 64'd0);
        chk({tag, "_cmp_last"}, 64'(cmp_Last), 64'd0);
        chk({tag, "_batch_done"}, 64'(batch_Done), 64'd0);
        chk({tag, "_batch_cnt"}, 64'(batch_Cnt), 64'd0);
        chk({tag, "_err_frame"}, 64'(err_Frame), 64'd0);
        chk({tag, "_busy"}, 64'(batch_Busy), 64'd0);
        chk({tag, "_up_ready"}, 64'(up_Ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        check_cleared("reset");

        // Nominal batch, up_Valid held high throughout
        do_batch(32'hA000_0000, 8'd0, 1'b0, 2'd1);

        // Compare-side backpressure for 5 cycles
        do_batch(32'hB000_0000, 8'd0, 1'b1, 2'd2);
        chk("err_none_yet", 64'(err_cnt), 64'd0);

        // Incomplete reference set: up_Last on the third reference sub-vector
        push_ref(0, 32'hC000_0000);
        send(32'hC000_0000, 8'd0, 1'b0);
        push_ref(1, 32'hC000_0001);
        send(32'hC000_0001, 8'd0, 1'b0);
        push_ref(2, 32'hC000_0002);
        send(32'hC000_0002, 8'd1, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        chk("load_err_pulse", 64'(err_cnt), 64'd1);
        chk("load_err_no_done", 64'(done_cnt), 64'd2);
        chk("load_err_state", 64'(batch_Busy), 64'd0);
        @(posedge clk);
        #1;

        // Next batch restarts at slot 0 / sub 0; its first query carries up_Last
        load_refs(32'hD000_0000, 8'd4);
        push_cmp(32'hD000_0010, 8'd6, 1'b1);
        send(32'hD000_0010, 8'd6, 1'b1);
        finish_batch(2'd3);
        chk("short_query_err", 64'(err_cnt), 64'd2);

        // Reset in the middle of CMP
        load_refs(32'hE000_0000, 8'd8);
        push_cmp(32'hE000_0004, 8'd10, 1'b0);
        send(32'hE000_0004, 8'd10, 1'b0);
        idle();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_cleared("midreset");
        chk("midreset_no_done", 64'(done_cnt), 64'd3);

        // Back-to-back batches: counter wraps 3 -> 0 -> 1
        for (int b = 0; b < 5; b++)
            do_batch(32'h1000_0000 * (b + 1), 8'(16 * b), 1'b0, BCW'(b + 1));

        repeat (2) @(negedge clk);
        chk("ref_queue_empty", 64'(ref_q.size()), 64'd0);
        chk("cmp_queue_empty", 64'(cmp_q.size()), 64'd0);
        chk("total_done", 64'(done_cnt), 64'd8);
        chk("total_err", 64'(err_cnt), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
